// File: rtl/global_pool_layer.sv
// Channel-interleaved global pooling: each channel's frame is reduced to one word
// (scaled saturating average or signed max), then the results are drained serially.
module global_pool_layer #(
   parameter int INPUT_SIZE = 4,
   parameter int N_CHANNELS = 2,
   parameter int WORD_SIZE  = 16,
   parameter int N_SIZE     = 8,
   parameter     MODE       = "avg",
   parameter int MULTIPLIER = (2 ** N_SIZE) / INPUT_SIZE
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic                        ready_o,
   input  logic                        valid_i,
   input  logic signed [WORD_SIZE-1:0] data_r_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic signed [WORD_SIZE-1:0] data_r_o
);

   localparam int CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int SMW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int PW  = WORD_SIZE + 32;
   localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CHANNELS - 1);
   localparam logic [SMW-1:0] SMP_LAST = SMW'(INPUT_SIZE - 1);
   localparam bit IS_MAX = (MODE == "max");

   localparam logic signed [PW-1:0] P_MAX = {{(PW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [PW-1:0] P_MIN = {{(PW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};
   localparam logic signed [WORD_SIZE-1:0] W_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [WORD_SIZE-1:0] W_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

   typedef enum logic {eACCUM, eDRAIN} state_t;

   state_t                       state;
   logic [CHW-1:0]               ch_cnt;
   logic [SMW-1:0]               smp_cnt;
   logic [CHW-1:0]               out_cnt;
   logic signed [WORD_SIZE-1:0]  acc [N_CHANNELS];

   logic signed [PW-1:0]         prod;
   logic signed [PW-1:0]         shifted;
   logic signed [WORD_SIZE-1:0]  term;
   logic signed [WORD_SIZE-1:0]  cur;
   logic signed [WORD_SIZE:0]    sum;
   logic signed [WORD_SIZE-1:0]  sum_sat;
   logic signed [WORD_SIZE-1:0]  upd;

   // Next accumulator value for the channel receiving the current sample.
   always_comb begin
      prod    = PW'(data_r_i) * PW'(MULTIPLIER);
      shifted = prod >>> N_SIZE;
      if (shifted > P_MAX)
         term = W_MAX;
      else if (shifted < P_MIN)
         term = W_MIN;
      else
         term = shifted[WORD_SIZE-1:0];
      cur = acc[ch_cnt];
      sum = {cur[WORD_SIZE-1], cur} + {term[WORD_SIZE-1], term};
      if (sum[WORD_SIZE] != sum[WORD_SIZE-1])
         sum_sat = sum[WORD_SIZE] ? W_MIN : W_MAX;
      else
         sum_sat = sum[WORD_SIZE-1:0];
      if (IS_MAX)
         upd = (smp_cnt == '0 || data_r_i > cur) ? data_r_i : cur;
      else
         upd = (smp_cnt == '0) ? term : sum_sat;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= eACCUM;
         ready_o  <= 1'b1;
         valid_o  <= 1'b0;
         data_r_o <= '0;
         ch_cnt   <= '0;
         smp_cnt  <= '0;
         out_cnt  <= '0;
         for (int i = 0; i < N_CHANNELS; i++)
            acc[i] <= '0;
      end else begin
         case (state)
            eACCUM: begin
               if (valid_i) begin
                  acc[ch_cnt] <= upd;
                  if (ch_cnt == CH_LAST) begin
                     ch_cnt <= '0;
                     if (smp_cnt == SMP_LAST) begin
                        smp_cnt <= '0;
                        state   <= eDRAIN;
                        ready_o <= 1'b0;
                        valid_o <= 1'b1;
                        // With one channel, channel 0 is the one finishing this cycle.
                        data_r_o <= (ch_cnt == '0) ? upd : acc[0];
                     end else begin
                        smp_cnt <= smp_cnt + SMW'(1);
                     end
                  end else begin
                     ch_cnt <= ch_cnt + CHW'(1);
                  end
               end
            end
            eDRAIN: begin
               if (ready_i) begin
                  if (out_cnt == CH_LAST) begin
                     out_cnt  <= '0;
                     state    <= eACCUM;
                     ready_o  <= 1'b1;
                     valid_o  <= 1'b0;
                     data_r_o <= '0;
                  end else begin
                     out_cnt  <= out_cnt + CHW'(1);
                     data_r_o <= acc[out_cnt + CHW'(1)];
                  end
               end
            end
            default: state <= eACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_global_pool_layer.sv
// Bench for global_pool_layer: avg (C=2,I=4), max (C=2,I=4) and avg (C=1,I=2,M=256)
// instances, driven through a shared stimulus port selected by 'sel'.
module tb_global_pool_layer;

   logic clk = 1'b0;
   logic reset;
   int   sel;
   logic valid_drv, ready_drv;
   logic signed [15:0] data_drv;

   logic [2:0] vin, rin, rdyv, vldv;
   logic signed [15:0] dv [3];

   logic rdy, vld;
   logic [15:0] dout;

   int checks = 0;
   int errors = 0;
   int fin [8];

   typedef struct packed {
      logic [1:0]        dsel;
      logic [3:0]        n_in;
      logic [1:0]        n_out;
      logic [0:7][15:0]  in;
      logic [0:1][15:0]  exp;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_drv
      assign vin[k] = valid_drv && (sel == k);
      assign rin[k] = (sel == k) ? ready_drv : 1'b1;
   end

   assign rdy  = rdyv[sel];
   assign vld  = vldv[sel];
   assign dout = dv[sel];

   global_pool_layer #(.INPUT_SIZE(4), .N_CHANNELS(2), .WORD_SIZE(16), .N_SIZE(8), .MODE("avg")) dut_avg (
      .clk_i(clk), .reset_i(reset), .ready_o(rdyv[0]), .valid_i(vin[0]), .data_r_i(data_drv),
      .valid_o(vldv[0]), .ready_i(rin[0]), .data_r_o(dv[0]));

   global_pool_layer #(.INPUT_SIZE(4), .N_CHANNELS(2), .WORD_SIZE(16), .N_SIZE(8), .MODE("max")) dut_max (
      .clk_i(clk), .reset_i(reset), .ready_o(rdyv[1]), .valid_i(vin[1]), .data_r_i(data_drv),
      .valid_o(vldv[1]), .ready_i(rin[1]), .data_r_o(dv[1]));

   global_pool_layer #(.INPUT_SIZE(2), .N_CHANNELS(1), .WORD_SIZE(16), .N_SIZE(8), .MODE("avg"),
                       .MULTIPLIER(256)) dut_sat (
      .clk_i(clk), .reset_i(reset), .ready_o(rdyv[2]), .valid_i(vin[2]), .data_r_i(data_drv),
      .valid_o(vldv[2]), .ready_i(rin[2]), .data_r_o(dv[2]));

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pooling result of one channel of the frame in fin[], from the layer's arithmetic rules.
   function automatic int refPool(input int s, input int ch);
      int     nc   = (s == 2) ? 1 : 2;
      int     ni   = (s == 2) ? 2 : 4;
      longint mult = (s == 2) ? 256 : 64;
      longint acc  = 0;
      longint x, p;
      for (int i = 0; i < ni; i++) begin
         x = longint'(fin[i*nc + ch]);
         if (s == 1) begin
            acc = (i == 0 || x > acc) ? x : acc;
         end else begin
            p = (x * mult) >>> 8;
            if (p > 32767) p = 32767;
            if (p < -32768) p = -32768;
            acc = (i == 0) ? p : acc + p;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
         end
      end
      return int'(acc);
   endfunction

   // Drives one sample; entered and left on a falling edge with valid_drv still high.
   task automatic applyStimulus(input logic signed [15:0] v);
      int t = 0;
      data_drv  = v;
      valid_drv = 1'b1;
      while (!rdy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("ready_o timeout", {15'd0, rdy}, 16'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] exp);
      int t = 0;
      ready_drv = 1'b1;
      while (!vld && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({name, " valid_o"}, {15'd0, vld}, 16'd1);
      check(name, dout, exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic runFrame(input int s, input int n_in, input bit keep_valid);
      sel = s;
      for (int i = 0; i < n_in; i++) applyStimulus(16'(fin[i]));
      check("latency valid_o", {15'd0, vld}, 16'd1);
      check("drain ready_o", {15'd0, rdy}, 16'd0);
      if (!keep_valid) valid_drv = 1'b0;
   endtask

   task automatic endCheck();
      check("idle valid_o", {15'd0, vld}, 16'd0);
      check("idle ready_o", {15'd0, rdy}, 16'd1);
   endtask

   task automatic loadVec(input int k);
      for (int i = 0; i < 8; i++) fin[i] = int'($signed(vecs[k].in[i]));
   endtask

   initial begin
      vecs[0] = '{dsel: 2'd0, n_in: 4'd8, n_out: 2'd2,
                  in: {16'h0100, 16'h0200, 16'h0100, 16'h0400, 16'h0100, 16'h0600, 16'h0100, 16'h0800},
                  exp: {16'h0100, 16'h0500}};
      vecs[1] = '{dsel: 2'd1, n_in: 4'd8, n_out: 2'd2,
                  in: {16'hFF00, 16'hFD00, 16'hFF00, 16'h0700, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0200},
                  exp: {16'hFF00, 16'h0700}};
      vecs[2] = '{dsel: 2'd2, n_in: 4'd2, n_out: 2'd1,
                  in: {16'h7000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                  exp: {16'h7FFF, 16'h0000}};
      vecs[3] = '{dsel: 2'd2, n_in: 4'd2, n_out: 2'd1,
                  in: {16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                  exp: {16'h8000, 16'h0000}};

      reset = 1'b1; sel = 0; valid_drv = 1'b0; ready_drv = 1'b1; data_drv = '0;
      #12;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         check("reset ready_o", {15'd0, rdy}, 16'd1);
         check("reset valid_o", {15'd0, vld}, 16'd0);
         check("reset data_r_o", dout, 16'h0000);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 4; k++) begin
         loadVec(k);
         runFrame(int'(vecs[k].dsel), int'(vecs[k].n_in), 1'b0);
         for (int j = 0; j < int'(vecs[k].n_out); j++) checkOutput("vector result", vecs[k].exp[j]);
         endCheck();
      end

      // Backpressure: results held, input pulses ignored while draining.
      loadVec(0);
      runFrame(0, 8, 1'b0);
      ready_drv = 1'b0;
      for (int c = 0; c < 5; c++) begin
         valid_drv = c[0];
         data_drv  = 16'h1234;
         check("stall valid_o", {15'd0, vld}, 16'd1);
         check("stall data_r_o", dout, 16'h0100);
         check("stall ready_o", {15'd0, rdy}, 16'd0);
         @(negedge clk);
      end
      valid_drv = 1'b0;
      checkOutput("after stall ch0", 16'h0100);
      checkOutput("after stall ch1", 16'h0500);
      endCheck();

      // Reset mid-frame discards the partial frame.
      sel = 0;
      applyStimulus(16'h7000);
      applyStimulus(16'h7000);
      applyStimulus(16'h7000);
      valid_drv = 1'b0;
      reset = 1'b1;
      #1;
      check("midreset valid_o", {15'd0, vld}, 16'd0);
      check("midreset data_r_o", dout, 16'h0000);
      check("midreset ready_o", {15'd0, rdy}, 16'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      loadVec(0);
      runFrame(0, 8, 1'b0);
      checkOutput("replay ch0", 16'h0100);
      checkOutput("replay ch1", 16'h0500);
      endCheck();

      // Back-to-back frames with valid_i and ready_i held high throughout.
      for (int s = 0; s < 2; s++) begin
         loadVec(s);
         runFrame(s, 8, 1'b1);
         data_drv = 16'h4444;
         checkOutput("b2b frame1 ch0", vecs[s].exp[0]);
         checkOutput("b2b frame1 ch1", vecs[s].exp[1]);
         for (int i = 0; i < 8; i++) fin[i] = int'($signed(16'($urandom)));
         runFrame(s, 8, 1'b0);
         checkOutput("b2b frame2 ch0", 16'(refPool(s, 0)));
         checkOutput("b2b frame2 ch1", 16'(refPool(s, 1)));
         endCheck();
      end

      // Random frames against the reference model.
      for (int r = 0; r < 24; r++) begin
         int s  = r % 3;
         int nc = (s == 2) ? 1 : 2;
         int ni = (s == 2) ? 2 : 4;
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0)
               fin[i] = int'($signed(16'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF)));
            else
               fin[i] = int'($signed(16'($urandom)));
         end
         runFrame(s, nc * ni, 1'b0);
         for (int c = 0; c < nc; c++) checkOutput("random result", 16'(refPool(s, c)));
         endCheck();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
